// File: rtl/tt_um_my_processor.sv
// Tiny Tapeout tile: registered 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier.
// Optional registered status bus on uio_out when MULT_STATUS_EN is defined.
module tt_um_my_processor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // 2x2 Vedic cell: vertical bit, crosswise half adder, then top bit plus carry.
  function automatic logic [3:0] vedic2(input logic [1:0] a, input logic [1:0] b);
    logic [3:0] p;
    logic       c1;
    p[0] = a[0] & b[0];
    p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    c1   = (a[1] & b[0]) & (a[0] & b[1]);
    p[2] = (a[1] & b[1]) ^ c1;
    p[3] = (a[1] & b[1]) & c1;
    return p;
  endfunction

  function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y);
    logic [4:0] s;
    logic       c;
    c = 1'b0;
    s = 5'd0;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    s[4] = c;
    return s;
  endfunction

  // Carry out is dropped: the full product never exceeds 225.
  function automatic logic [5:0] ripple6(input logic [5:0] x, input logic [5:0] y);
    logic [5:0] s;
    logic       c;
    c = 1'b0;
    s = 6'd0;
    for (int i = 0; i < 6; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return s;
  endfunction

  logic [3:0] op_a, op_b;
  logic [3:0] pp_ll, pp_hl, pp_lh, pp_hh;
  logic [4:0] cross_sum;
  logic [5:0] upper_sum;
  logic [7:0] prod_d, prod_q;
  logic       unused_uio;

  assign op_a = ui_in[3:0];
  assign op_b = ui_in[7:4];

  assign pp_ll = vedic2(op_a[1:0], op_b[1:0]);
  assign pp_hl = vedic2(op_a[3:2], op_b[1:0]);
  assign pp_lh = vedic2(op_a[1:0], op_b[3:2]);
  assign pp_hh = vedic2(op_a[3:2], op_b[3:2]);

  // Both cross products carry weight 4, so sum them first and add above bit 1.
  assign cross_sum = ripple4(pp_hl, pp_lh);
  assign upper_sum = ripple6({pp_hh, pp_ll[3:2]}, {1'b0, cross_sum});
  assign prod_d    = {upper_sum, pp_ll[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= 8'h00;
    end else if (ena) begin
      prod_q <= prod_d;
    end
  end

  assign uo_out     = prod_q;
  assign unused_uio = ^uio_in;

`ifdef MULT_STATUS_EN
  logic [7:0] status_d, status_q;

  always_comb begin
    status_d    = 8'h00;
    status_d[0] = (prod_d == 8'h00);
    status_d[1] = ^prod_d;
    status_d[2] = (op_a == 4'hF) && (op_b == 4'hF);
    status_d[3] = (prod_d >= 8'h80);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 8'h00;
    end else if (ena) begin
      status_q <= status_d;
    end
  end

  assign uio_out = status_q;
  assign uio_oe  = 8'hFF;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_my_processor.sv
// Directed bench for tt_um_my_processor: scoreboard of expected products/status,
// popped and compared one cycle after each enabled edge.
module tb_tt_um_my_processor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] sb_q[$];

  tt_um_my_processor dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] model_prod(input logic [7:0] v);
    logic [7:0] a, b;
    a = {4'h0, v[3:0]};
    b = {4'h0, v[7:4]};
    return a * b;
  endfunction

  function automatic logic [7:0] model_status(input logic [7:0] v);
    logic [7:0] p, st;
    p  = model_prod(v);
    st = 8'h00;
`ifdef MULT_STATUS_EN
    st = {4'h0, (p >= 8'h80), (v == 8'hFF), ^p, (p == 8'h00)};
`endif
    return st;
  endfunction

  function automatic logic [7:0] expected_oe();
`ifdef MULT_STATUS_EN
    return 8'hFF;
`else
    return 8'h00;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one enabled operand pair, then compare one cycle later against the scoreboard.
  task automatic step(input logic [7:0] v, input string tag);
    logic [15:0] exp;
    ui_in = v;
    ena   = 1'b1;
    sb_q.push_back({model_prod(v), model_status(v)});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 8'hFF, 8'h00);
    end else begin
      exp = sb_q.pop_front();
      check(tag, uo_out, exp[15:8]);
      check({tag, "_st"}, uio_out, exp[7:0]);
      check({tag, "_oe"}, uio_oe, expected_oe());
      $display("step %s ui_in=%h uo_out=%h uio_out=%h", tag, v, uo_out, uio_out);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    check("reset_prod", uo_out, 8'h00);
    check("reset_st", uio_out, 8'h00);
    check("reset_oe", uio_oe, expected_oe());
    #3 rst_n = 1'b1;

    step(8'h53, "a3b5");
    step(8'h27, "a7b2");
    step(8'h49, "a9b4");
    step(8'hFF, "a15b15");
    step(8'h90, "a0b9");
    step(8'h0F, "a15b0");
    step(8'hB1, "a1b11");

    // Operand change between edges must not reach the output before the edge.
    ui_in = 8'h33;
    #2;
    check("latency_pre", uo_out, 8'd11);
    step(8'h33, "a3b3");

    // ena low: register holds while operands change.
    ena   = 1'b0;
    ui_in = 8'hFF;
    @(posedge clk); #1;
    check("hold1", uo_out, 8'd9);
    ui_in = 8'h77;
    @(posedge clk); #1;
    check("hold2", uo_out, 8'd9);
    step(8'h77, "ena_resume");

    // Asynchronous reset mid-stream with a nonzero product.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_prod", uo_out, 8'h00);
    check("async_rst_st", uio_out, 8'h00);
    ena = 1'b1;
    ui_in = 8'hFF;
    @(posedge clk); #1;
    check("rst_held", uo_out, 8'h00);
    #3 rst_n = 1'b1;
    step(8'h53, "post_rst");

    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = i[7:0];
      step(v, "sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
